serial_twos_negator: RTL and testbench
======================================

// Module: serial_twos_negator
// PURPOSE
//  Multi-cycle, parametrised two's-complement unit: pass, negate or absolute value.
//  It processes DIGIT bits per cycle, LSB first, and carries a ripple carry between digits.
//  It sits between operand sources and the adder/subtractor datapath.
//  Each side uses a valid/ready handshake. There is one operation in flight at a time.
// PARAMETERS
//  WIDTH  8  operand/result width in bits (>=2)
//  DIGIT  1  bits processed per cycle; must divide WIDTH; N = WIDTH/DIGIT cycles
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      operand/mode valid
//  in_ready   out  1      unit can accept (high only in IDLE)
//  in_num     in   WIDTH  operand (two's complement)
//  in_mode    in   2      00 pass, 01 negate, 10 abs, 11 pass (reserved)
//  out_valid  out  1      result valid (high only in DONE)
//  out_ready  in   1      consumer accepts result
//  out_num    out  WIDTH  result
//  out_ovf    out  1      overflow: inverted an operand equal to 1 followed by WIDTH-1 zeros
//  out_zero   out  1      out_num == 0
// BEHAVIOUR
//  Reset: state=IDLE, in_ready=1, out_valid=0, out_num=0, out_ovf=0, out_zero=0.
//   Digit counter and carry are cleared.
//  FSM IDLE -> BUSY -> DONE -> IDLE.
//  IDLE: in_ready=1. On an edge with in_valid=1, latch in_num and compute inv:
//   mode 01: inv=1. mode 10: inv=in_num[WIDTH-1]. Otherwise inv=0.
//   Also set carry=inv, count=0, then go to BUSY.
//  BUSY: in_ready=0, out_valid=0. Each edge produces one DIGIT-bit result slice,
//   using slice index = count:
//   {c, r} = (operand_slice ^ {DIGIT{inv}}) + carry
//   Store r into the result slice, set carry=c, count=count+1.
//   On the edge that processes slice N-1, go to DONE.
//  Latency: out_valid rises exactly N edges after the accepting edge (WIDTH=8, DIGIT=1 gives 8).
//  DONE: out_valid=1. out_num, out_ovf and out_zero stay stable until the handshake.
//   On an edge with out_ready=1, go to IDLE. out_num and the flags hold their last values.
//   No new operand is accepted in the same edge. in_ready rises the cycle after.
//  out_ovf=1 iff inv=1 and operand == {1'b1,{WIDTH-1{1'b0}}}. The result is then the operand unchanged.
//   Negating or abs of 0 gives 0, with out_ovf=0 and out_zero=1.
//  The final carry out is discarded. Arithmetic is modulo 2^WIDTH.
//  in_valid and in_mode are ignored outside IDLE. out_ready is ignored outside DONE.
//  Reset has priority in any state: an in-flight operation is discarded, no result is
//   presented, and all outputs take their reset values on the next edge.
//  Mode 11 behaves exactly as mode 00.
// TESTING
//  1. WIDTH=8, DIGIT=1, mode 01, in_num=8'h05, out_ready=1
//     -> out_num=8'hFB, ovf=0, zero=0; out_valid exactly 8 edges after accept.
//  2. mode 10, in_num=8'hF6 -> 8'h0A.
//     mode 10, in_num=8'h80 -> 8'h80 with ovf=1.
//     mode 10, in_num=8'h3C -> 8'h3C with ovf=0.
//  3. mode 00, in_num=8'h5A -> 8'h5A.
//     mode 01, in_num=8'h00 -> 8'h00, zero=1, ovf=0.
//  4. Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid and out_num stable,
//     in_ready=0, a pulsed in_valid is ignored. Release -> IDLE next edge, in_ready=1.
//  5. Assert rst at BUSY count=3 -> next edge: IDLE, in_ready=1, out_valid=0.
//     A fresh negate of 8'h01 -> 8'hFF.
//  6. WIDTH=16, DIGIT=4: negate 16'h1234 -> 16'hEDCC in 4 cycles.
//     Back-to-back random operands vs. a reference model, 1000 ops, random out_ready.

Source files
------------

// File: rtl/serial_twos_negator_if.sv
// Valid/ready bundle for the serial two's-complement unit: operand/mode in, result/flags out.
// The master side feeds operands and consumes results; the slave side is the unit itself.
interface serial_twos_negator_if #(
    parameter int unsigned WIDTH = 8
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_num;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_num;
    logic             out_ovf;
    logic             out_zero;

    modport master (
        output in_valid,
        input  in_ready,
        output in_num,
        output in_mode,
        input  out_valid,
        output out_ready,
        input  out_num,
        input  out_ovf,
        input  out_zero
    );

    modport slave (
        input  in_valid,
        output in_ready,
        input  in_num,
        input  in_mode,
        output out_valid,
        input  out_ready,
        output out_num,
        output out_ovf,
        output out_zero
    );
endinterface

// File: rtl/serial_twos_negator.sv
// Digit-serial pass / negate / abs unit: conditionally inverts the operand and ripples the +1
// through WIDTH/DIGIT cycles, LSB slice first, one operation in flight at a time.
module serial_twos_negator #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    serial_twos_negator_if.slave  bus
);
    localparam int unsigned     N       = WIDTH / DIGIT;
    localparam int unsigned     CW      = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0]   LAST    = CW'(N - 1);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] operand;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] result;
    logic [CW-1:0]    count;
    logic             inv;
    logic             carry;
    logic             ovf_pend;
    logic             ovf;
    logic             zero;
    logic             inv_in;
    logic             last_slice;
    logic [DIGIT:0]   sum;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.in_valid) state_next = BUSY;
            BUSY:    if (last_slice)   state_next = DONE;
            DONE:    if (bus.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.out_valid = (state == DONE);
        bus.out_num   = result;
        bus.out_ovf   = ovf;
        bus.out_zero  = zero;
    end

    always_comb begin
        case (bus.in_mode)
            2'b01:   inv_in = 1'b1;
            2'b10:   inv_in = bus.in_num[WIDTH-1];
            default: inv_in = 1'b0;
        endcase
    end

    // The operand is shifted down so slice 0 is always the live digit; result slices enter
    // at the top of acc, so after N shifts acc holds the complete result in place.
    always_comb begin
        last_slice = (state == BUSY) && (count == LAST);
        sum        = {1'b0, operand[DIGIT-1:0] ^ {DIGIT{inv}}} + {{DIGIT{1'b0}}, carry};
        acc_next   = (acc >> DIGIT) | (WIDTH'(sum[DIGIT-1:0]) << (WIDTH - DIGIT));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            operand  <= '0;
            acc      <= '0;
            result   <= '0;
            count    <= '0;
            inv      <= 1'b0;
            carry    <= 1'b0;
            ovf_pend <= 1'b0;
            ovf      <= 1'b0;
            zero     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        operand  <= bus.in_num;
                        inv      <= inv_in;
                        carry    <= inv_in;
                        count    <= '0;
                        ovf_pend <= inv_in && (bus.in_num == MIN_VAL);
                    end
                end
                BUSY: begin
                    operand <= operand >> DIGIT;
                    acc     <= acc_next;
                    carry   <= sum[DIGIT];
                    count   <= count + 1'b1;
                    // Published outputs change only on the final slice so they stay stable until the next DONE.
                    if (last_slice) begin
                        result <= acc_next;
                        ovf    <= ovf_pend;
                        zero   <= (acc_next == '0);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_twos_negator.sv
// Self-checking bench for serial_twos_negator: directed cases plus random traffic
// against an arithmetic reference model, on an 8x1 and a 16x4 configuration.
module tb_serial_twos_negator;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    serial_twos_negator_if #(.WIDTH(8))  bus8  ();
    serial_twos_negator_if #(.WIDTH(16)) bus16 ();

    serial_twos_negator #(.WIDTH(8), .DIGIT(1)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8.slave)
    );

    serial_twos_negator #(.WIDTH(16), .DIGIT(4)) dut16 (
        .clk (clk),
        .rst (rst),
        .bus (bus16.slave)
    );

    typedef struct packed {
        logic [31:0] res;
        logic        ovf;
        logic        zero;
    } exp_t;

    // Reference: two's-complement rules in plain modular arithmetic.
    function automatic exp_t ref_model(int unsigned w, logic [1:0] mode, logic [31:0] x);
        exp_t e;
        longint unsigned m    = 64'd1 << w;
        longint unsigned xv   = {32'd0, x};
        bit              neg  = (xv >= (m >> 1));
        bit              doit = (mode == 2'b01) || (mode == 2'b10 && neg);
        longint unsigned r    = doit ? ((m - xv) % m) : xv;
        e.res  = r[31:0];
        e.ovf  = doit && (xv == (m >> 1));
        e.zero = (r == 0);
        return e;
    endfunction

    function automatic logic [31:0] pick_operand(int unsigned w);
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0:       v = 32'd0;
            1:       v = 32'd1 << (w - 1);
            2:       v = (32'd1 << w) - 1;
            3:       v = 32'd1;
            default: v = $urandom & ((32'd1 << w) - 1);
        endcase
        return v;
    endfunction

    task automatic op8(input logic [1:0] mode, input logic [7:0] num, input bit rnd_ready,
                       output logic [7:0] res, output logic ovf, output logic zero,
                       output int lat, output bit stable);
        int guard = 0;
        bit hs;
        while (!bus8.in_ready && guard < 50) begin @(posedge clk); #1; guard++; end
        bus8.in_valid = 1'b1;
        bus8.in_mode  = mode;
        bus8.in_num   = num;
        @(posedge clk); #1;
        bus8.in_valid = 1'b0;
        bus8.in_mode  = 2'($urandom);
        bus8.in_num   = 8'($urandom);
        lat = 0;
        while (!bus8.out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        res    = bus8.out_num;
        ovf    = bus8.out_ovf;
        zero   = bus8.out_zero;
        stable = 1'b1;
        bus8.out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        guard = 0;
        do begin
            hs = bus8.out_ready;
            @(posedge clk); #1;
            if (!hs) begin
                if (!bus8.out_valid || bus8.out_num !== res || bus8.out_ovf !== ovf ||
                    bus8.out_zero !== zero || bus8.in_ready)
                    stable = 1'b0;
                bus8.out_ready = 1'($urandom_range(0, 1));
            end
            guard++;
        end while (!hs && guard < 100);
        bus8.out_ready = 1'b0;
    endtask

    task automatic op16(input logic [1:0] mode, input logic [15:0] num, input bit rnd_ready,
                        output logic [15:0] res, output logic ovf, output logic zero,
                        output int lat, output bit stable);
        int guard = 0;
        bit hs;
        while (!bus16.in_ready && guard < 50) begin @(posedge clk); #1; guard++; end
        bus16.in_valid = 1'b1;
        bus16.in_mode  = mode;
        bus16.in_num   = num;
        @(posedge clk); #1;
        bus16.in_valid = 1'b0;
        bus16.in_mode  = 2'($urandom);
        bus16.in_num   = 16'($urandom);
        lat = 0;
        while (!bus16.out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        res    = bus16.out_num;
        ovf    = bus16.out_ovf;
        zero   = bus16.out_zero;
        stable = 1'b1;
        bus16.out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        guard = 0;
        do begin
            hs = bus16.out_ready;
            @(posedge clk); #1;
            if (!hs) begin
                if (!bus16.out_valid || bus16.out_num !== res || bus16.out_ovf !== ovf ||
                    bus16.out_zero !== zero || bus16.in_ready)
                    stable = 1'b0;
                bus16.out_ready = 1'($urandom_range(0, 1));
            end
            guard++;
        end while (!hs && guard < 100);
        bus16.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus8.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus8.in_ready); end
        checks++; if (bus8.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus8.out_valid); end
        checks++; if (bus8.out_num !== 8'h00) begin errors++; $display("FAIL reset_out_num got %h want 00", bus8.out_num); end
        checks++; if ({bus8.out_ovf, bus8.out_zero} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b want 00", {bus8.out_ovf, bus8.out_zero}); end
        checks++; if (bus16.in_ready !== 1'b1 || bus16.out_valid !== 1'b0) begin errors++; $display("FAIL reset16_hs got %b%b want 10", bus16.in_ready, bus16.out_valid); end
        rst = 1'b0;
    endtask

    task automatic test_negate();
        logic [7:0] r; logic o, z; int lat; bit st;
        op8(2'b01, 8'h05, 1'b0, r, o, z, lat, st);
        checks++; if (r !== 8'hFB) begin errors++; $display("FAIL neg05_num got %h want FB", r); end
        checks++; if ({o, z} !== 2'b00) begin errors++; $display("FAIL neg05_flags got %b want 00", {o, z}); end
        checks++; if (lat !== 8) begin errors++; $display("FAIL neg05_latency got %0d want 8", lat); end
    endtask

    task automatic test_abs();
        logic [7:0] r; logic o, z; int lat; bit st;
        op8(2'b10, 8'hF6, 1'b0, r, o, z, lat, st);
        checks++; if (r !== 8'h0A || o !== 1'b0) begin errors++; $display("FAIL absF6 got %h/%b want 0A/0", r, o); end
        op8(2'b10, 8'h80, 1'b0, r, o, z, lat, st);
        checks++; if (r !== 8'h80 || o !== 1'b1 || z !== 1'b0) begin errors++; $display("FAIL abs80 got %h/%b/%b want 80/1/0", r, o, z); end
        op8(2'b10, 8'h3C, 1'b0, r, o, z, lat, st);
        checks++; if (r !== 8'h3C || o !== 1'b0) begin errors++; $display("FAIL abs3C got %h/%b want 3C/0", r, o); end
    endtask

    task automatic test_pass();
        logic [7:0] r; logic o, z; int lat; bit st;
        op8(2'b00, 8'h5A, 1'b0, r, o, z, lat, st);
        checks++; if (r !== 8'h5A || o !== 1'b0) begin errors++; $display("FAIL pass5A got %h/%b want 5A/0", r, o); end
        op8(2'b11, 8'hA5, 1'b0, r, o, z, lat, st);
        checks++; if (r !== 8'hA5 || o !== 1'b0) begin errors++; $display("FAIL mode11_A5 got %h/%b want A5/0", r, o); end
        op8(2'b11, 8'h80, 1'b0, r, o, z, lat, st);
        checks++; if (r !== 8'h80 || o !== 1'b0) begin errors++; $display("FAIL mode11_80 got %h/%b want 80/0", r, o); end
        op8(2'b01, 8'h00, 1'b0, r, o, z, lat, st);
        checks++; if (r !== 8'h00 || o !== 1'b0 || z !== 1'b1) begin errors++; $display("FAIL neg00 got %h/%b/%b want 00/0/1", r, o, z); end
        op8(2'b10, 8'h00, 1'b0, r, o, z, lat, st);
        checks++; if (r !== 8'h00 || o !== 1'b0 || z !== 1'b1) begin errors++; $display("FAIL abs00 got %h/%b/%b want 00/0/1", r, o, z); end
    endtask

    task automatic test_backpressure();
        int lat = 0;
        bus8.in_valid = 1'b1; bus8.in_mode = 2'b01; bus8.in_num = 8'h33;
        @(posedge clk); #1;
        bus8.in_valid = 1'b0;
        while (!bus8.out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        checks++; if (lat !== 8) begin errors++; $display("FAIL bp_latency got %0d want 8", lat); end
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin bus8.in_valid = 1'b1; bus8.in_mode = 2'b01; bus8.in_num = 8'h11; end
            @(posedge clk); #1;
            bus8.in_valid = 1'b0;
            checks++;
            if (bus8.out_valid !== 1'b1 || bus8.out_num !== 8'hCD || bus8.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d got v=%b num=%h rdy=%b want v=1 num=CD rdy=0", i, bus8.out_valid, bus8.out_num, bus8.in_ready);
            end
        end
        bus8.out_ready = 1'b1;
        bus8.in_valid  = 1'b1; bus8.in_num = 8'h22; bus8.in_mode = 2'b01;
        @(posedge clk); #1;
        bus8.in_valid  = 1'b0;
        bus8.out_ready = 1'b0;
        checks++;
        if (bus8.out_valid !== 1'b0 || bus8.in_ready !== 1'b1 || bus8.out_num !== 8'hCD) begin
            errors++;
            $display("FAIL bp_release got v=%b rdy=%b num=%h want v=0 rdy=1 num=CD", bus8.out_valid, bus8.in_ready, bus8.out_num);
        end
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (bus8.out_valid !== 1'b0 || bus8.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_no_accept got v=%b rdy=%b want v=0 rdy=1", bus8.out_valid, bus8.in_ready);
        end
    endtask

    task automatic test_reset_midflight();
        logic [7:0] r; logic o, z; int lat; bit st;
        bus8.in_valid = 1'b1; bus8.in_mode = 2'b01; bus8.in_num = 8'h5A;
        @(posedge clk); #1;
        bus8.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (bus8.in_ready !== 1'b1 || bus8.out_valid !== 1'b0 || bus8.out_num !== 8'h00 ||
            bus8.out_ovf !== 1'b0 || bus8.out_zero !== 1'b0) begin
            errors++;
            $display("FAIL midrst got rdy=%b v=%b num=%h ovf=%b zero=%b want 1 0 00 0 0",
                     bus8.in_ready, bus8.out_valid, bus8.out_num, bus8.out_ovf, bus8.out_zero);
        end
        repeat (10) @(posedge clk);
        #1;
        checks++; if (bus8.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_no_result got %b want 0", bus8.out_valid); end
        op8(2'b01, 8'h01, 1'b0, r, o, z, lat, st);
        checks++; if (r !== 8'hFF || o !== 1'b0 || z !== 1'b0 || lat !== 8) begin errors++; $display("FAIL midrst_neg01 got %h/%b/%b lat %0d want FF/0/0 lat 8", r, o, z, lat); end
    endtask

    task automatic test_wide();
        logic [15:0] r; logic o, z; int lat; bit st;
        op16(2'b01, 16'h1234, 1'b0, r, o, z, lat, st);
        checks++; if (r !== 16'hEDCC || o !== 1'b0 || z !== 1'b0) begin errors++; $display("FAIL wide_neg1234 got %h/%b/%b want EDCC/0/0", r, o, z); end
        checks++; if (lat !== 4) begin errors++; $display("FAIL wide_latency got %0d want 4", lat); end
        op16(2'b01, 16'h8000, 1'b0, r, o, z, lat, st);
        checks++; if (r !== 16'h8000 || o !== 1'b1) begin errors++; $display("FAIL wide_neg8000 got %h/%b want 8000/1", r, o); end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [1:0] mode;
        logic [31:0] x;
        logic [15:0] r16; logic [7:0] r8; logic o, z; int lat; bit st;
        for (int i = 0; i < 1000; i++) begin
            mode = 2'($urandom_range(0, 3));
            x    = pick_operand(16);
            e    = ref_model(16, mode, x);
            op16(mode, x[15:0], 1'b1, r16, o, z, lat, st);
            checks++;
            if (r16 !== e.res[15:0] || o !== e.ovf || z !== e.zero || lat !== 4 || !st) begin
                errors++;
                $display("FAIL rand16 #%0d mode %0d in %h got %h/%b/%b lat %0d stable %0d want %h/%b/%b lat 4 stable 1",
                         i, mode, x[15:0], r16, o, z, lat, st, e.res[15:0], e.ovf, e.zero);
            end
        end
        for (int i = 0; i < 200; i++) begin
            mode = 2'($urandom_range(0, 3));
            x    = pick_operand(8);
            e    = ref_model(8, mode, x);
            op8(mode, x[7:0], 1'b1, r8, o, z, lat, st);
            checks++;
            if (r8 !== e.res[7:0] || o !== e.ovf || z !== e.zero || lat !== 8 || !st) begin
                errors++;
                $display("FAIL rand8 #%0d mode %0d in %h got %h/%b/%b lat %0d stable %0d want %h/%b/%b lat 8 stable 1",
                         i, mode, x[7:0], r8, o, z, lat, st, e.res[7:0], e.ovf, e.zero);
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        bus8.in_valid   = 1'b0; bus8.in_num  = '0; bus8.in_mode  = 2'b00; bus8.out_ready  = 1'b0;
        bus16.in_valid  = 1'b0; bus16.in_num = '0; bus16.in_mode = 2'b00; bus16.out_ready = 1'b0;
        test_reset();
        test_negate();
        test_abs();
        test_pass();
        test_backpressure();
        test_reset_midflight();
        test_wide();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
